// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge event arbiter.
package edge_evt_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   // Channel index width; a single-bit index is kept even for tiny channel counts.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/edge_capture_cell.sv
// One channel: rising-edge detector plus a single-entry timestamped capture slot.
module edge_capture_cell #(
   parameter int TS_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sig,
   input  logic [TS_W-1:0] ts_ctr,
   input  logic            take,
   output logic            pending,
   output logic [TS_W-1:0] ts,
   output logic            drop
);

   logic prev;
   logic rise;

   assign rise = sig & ~prev;
   // An edge is lost only when the slot is full and is not being emptied this clock.
   assign drop = rise & pending & ~take;

   // Edge history and slot update; a slot being handed to the output can take a new edge at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev    <= 1'b0;
         pending <= 1'b0;
         ts      <= '0;
      end else begin
         prev <= sig;
         if (rise && (!pending || take)) begin
            pending <= 1'b1;
            ts      <= ts_ctr;
         end else if (take) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/edge_event_arbiter.sv
// Timestamped rising-edge capture on N_CH inputs, serialised round-robin onto a valid/ready stream.
module edge_event_arbiter
   import edge_evt_pkg::*;
#(
   parameter  int N_CH  = 4,
   parameter  int TS_W  = 16,
   parameter  int CNT_W = 8,
   localparam int IDX_W = idx_width(N_CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  sig_in,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [IDX_W-1:0] evt_ch,
   output logic [TS_W-1:0]  evt_ts,
   output logic [N_CH-1:0]  pending,
   output logic [CNT_W-1:0] drop_cnt,
   input  logic             clr_drop
);

   localparam int SUM_W = CNT_W + 5;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state;
   state_t            state_next;
   logic [TS_W-1:0]   ts_ctr;
   logic [TS_W-1:0]   ts_slot [N_CH];
   logic [N_CH-1:0]   take;
   logic [N_CH-1:0]   drops;
   logic [IDX_W-1:0]  last_grant;
   logic [IDX_W-1:0]  winner;
   logic              any_pending;
   logic              load;
   logic [SUM_W-1:0]  drop_sum;
   logic [CNT_W-1:0]  drop_next;

   for (genvar i = 0; i < N_CH; i++) begin : g_cell
      edge_capture_cell #(
         .TS_W(TS_W)
      ) u_cell (
         .clk    (clk),
         .rst    (rst),
         .sig    (sig_in[i]),
         .ts_ctr (ts_ctr),
         .take   (take[i]),
         .pending(pending[i]),
         .ts     (ts_slot[i]),
         .drop   (drops[i])
      );
   end

   // Free-running timestamp source, wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_ctr <= '0;
      end else begin
         ts_ctr <= ts_ctr + 1'b1;
      end
   end

   // Round-robin search starting just after the last granted channel.
   always_comb begin
      int idx;
      idx         = 0;
      winner      = '0;
      any_pending = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         idx = (int'(last_grant) + k) % N_CH;
         if (!any_pending && pending[idx]) begin
            winner      = IDX_W'(idx);
            any_pending = 1'b1;
         end
      end
   end

   // Next-state logic: load a new event whenever the output register is empty or being consumed.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (any_pending) begin
               load       = 1'b1;
               state_next = OFFER;
            end
         end
         OFFER: begin
            if (evt_ready) begin
               if (any_pending) begin
                  load = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // One-hot release of the winning slot when it moves into the output register.
   always_comb begin
      take = '0;
      if (load) begin
         take[winner] = 1'b1;
      end
   end

   assign evt_valid = (state == OFFER);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Output event register and arbitration pointer; held stable until a handshake reloads them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_ch     <= '0;
         evt_ts     <= '0;
         last_grant <= IDX_W'(N_CH - 1);
      end else if (load) begin
         evt_ch     <= winner;
         evt_ts     <= ts_slot[winner];
         last_grant <= winner;
      end
   end

   // Drop tally for this clock, added to the (possibly cleared) count and saturated.
   always_comb begin
      drop_sum = clr_drop ? '0 : SUM_W'(drop_cnt);
      for (int i = 0; i < N_CH; i++) begin
         drop_sum = drop_sum + SUM_W'(drops[i]);
      end
      drop_next = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
   end

   // Drop counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else begin
         drop_cnt <= drop_next;
      end
   end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed vector table, async-reset sequence, random run against a model.
module tb_edge_event_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  sig_in;
   logic        evt_valid;
   logic        evt_ready;
   logic [1:0]  evt_ch;
   logic [15:0] evt_ts;
   logic [3:0]  pending;
   logic [1:0]  drop_cnt;
   logic        clr_drop;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      bit          rst_first;
      int          cycles;
      logic [3:0]  sig;
      logic        ready;
      logic        clr;
      logic        exp_valid;
      logic [1:0]  exp_ch;
      logic [15:0] exp_ts;
      logic [3:0]  exp_pend;
      logic [1:0]  exp_drop;
      string       name;
   } vec_t;

   vec_t vecs[$];

   // Reference model state (abstract: arrays of flags and timestamps, no FSM).
   bit [3:0] m_prev;
   bit [3:0] m_pend;
   int       m_pts [4];
   int       m_ctr;
   bit       m_valid;
   int       m_ch;
   int       m_ts;
   int       m_lg;
   int       m_drop;

   edge_event_arbiter #(
      .N_CH (4),
      .TS_W (16),
      .CNT_W(2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sig_in   (sig_in),
      .evt_valid(evt_valid),
      .evt_ready(evt_ready),
      .evt_ch   (evt_ch),
      .evt_ts   (evt_ts),
      .pending  (pending),
      .drop_cnt (drop_cnt),
      .clr_drop (clr_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(bit rf, int cyc, logic [3:0] s, logic r, logic c,
                               logic v, logic [1:0] ch, logic [15:0] ts,
                               logic [3:0] p, logic [1:0] d, string nm);
      vec_t e;
      e.rst_first = rf; e.cycles = cyc; e.sig = s; e.ready = r; e.clr = c;
      e.exp_valid = v; e.exp_ch = ch; e.exp_ts = ts; e.exp_pend = p; e.exp_drop = d;
      e.name = nm;
      vecs.push_back(e);
   endfunction

   task automatic check_output(input string nm, input logic v, input logic [1:0] ch,
                               input logic [15:0] ts, input logic [3:0] p, input logic [1:0] d);
      bit ok;
      ok = (evt_valid === v) && (pending === p) && (drop_cnt === d);
      if (v) ok = ok && (evt_ch === ch) && (evt_ts === ts);
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("[TB] FAIL %s: got valid=%b ch=%0d ts=%0d pend=%b drop=%0d, want valid=%b ch=%0d ts=%0d pend=%b drop=%0d",
                  nm, evt_valid, evt_ch, evt_ts, pending, drop_cnt, v, ch, ts, p, d);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic apply_stimulus(input vec_t e);
      if (e.rst_first) begin
         sig_in = 4'b0000;
         do_reset();
      end
      sig_in    = e.sig;
      evt_ready = e.ready;
      clr_drop  = e.clr;
      repeat (e.cycles) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      m_prev = '0; m_pend = '0; m_ctr = 0; m_valid = 0;
      m_ch = 0; m_ts = 0; m_lg = 3; m_drop = 0;
      for (int i = 0; i < 4; i++) m_pts[i] = 0;
   endtask

   // Model one clock: outgoing event chosen from the slots as they stood, then edges are applied.
   task automatic model_step(input logic [3:0] s, input logic r, input logic c);
      bit [3:0] edges;
      bit       hs;
      int       w;
      int       j;
      int       drops;
      edges = s & ~m_prev;
      hs    = m_valid && r;
      w     = -1;
      for (int k = 1; k <= 4; k++) begin
         j = (m_lg + k) % 4;
         if (w < 0 && m_pend[j]) w = j;
      end
      if ((!m_valid || hs) && w >= 0) begin
         m_valid = 1; m_ch = w; m_ts = m_pts[w]; m_lg = w; m_pend[w] = 0;
      end else if (hs) begin
         m_valid = 0;
      end
      drops = 0;
      for (int i = 0; i < 4; i++) begin
         if (edges[i]) begin
            if (!m_pend[i]) begin
               m_pend[i] = 1; m_pts[i] = m_ctr;
            end else begin
               drops++;
            end
         end
      end
      m_drop = (c ? 0 : m_drop) + drops;
      if (m_drop > 3) m_drop = 3;
      m_ctr  = (m_ctr + 1) % 65536;
      m_prev = s;
   endtask

   initial begin
      rst = 1'b1; sig_in = '0; evt_ready = 1'b0; clr_drop = 1'b0;

      // single edge, latency and handshake
      add(1, 10, 4'b0000, 0, 0, 0, 0, 0,  4'b0000, 0, "t1_idle");
      add(0, 1,  4'b0100, 0, 0, 0, 0, 0,  4'b0100, 0, "t1_capture");
      add(0, 1,  4'b0100, 1, 0, 1, 2, 10, 4'b0000, 0, "t1_offer");
      add(0, 1,  4'b0000, 1, 0, 0, 0, 0,  4'b0000, 0, "t1_accept");
      // simultaneous edges at full throughput
      add(1, 20, 4'b0000, 1, 0, 0, 0, 0,  4'b0000, 0, "t2_idle");
      add(0, 1,  4'b1111, 1, 0, 0, 0, 0,  4'b1111, 0, "t2_capture");
      add(0, 1,  4'b1111, 1, 0, 1, 0, 20, 4'b1110, 0, "t2_ch0");
      add(0, 1,  4'b1111, 1, 0, 1, 1, 20, 4'b1100, 0, "t2_ch1");
      add(0, 1,  4'b1111, 1, 0, 1, 2, 20, 4'b1000, 0, "t2_ch2");
      add(0, 1,  4'b1111, 1, 0, 1, 3, 20, 4'b0000, 0, "t2_ch3");
      add(0, 1,  4'b1111, 1, 0, 0, 0, 0,  4'b0000, 0, "t2_done");
      // back-pressure, second capture and a drop
      add(1, 10, 4'b0000, 0, 0, 0, 0, 0,  4'b0000, 0, "t3_idle");
      add(0, 1,  4'b0010, 0, 0, 0, 0, 0,  4'b0010, 0, "t3_cap10");
      add(0, 1,  4'b0010, 0, 0, 1, 1, 10, 4'b0000, 0, "t3_offer10");
      add(0, 2,  4'b0000, 0, 0, 1, 1, 10, 4'b0000, 0, "t3_hold");
      add(0, 1,  4'b0010, 0, 0, 1, 1, 10, 4'b0010, 0, "t3_cap14");
      add(0, 3,  4'b0000, 0, 0, 1, 1, 10, 4'b0010, 0, "t3_hold2");
      add(0, 1,  4'b0010, 0, 0, 1, 1, 10, 4'b0010, 1, "t3_drop18");
      add(0, 1,  4'b0010, 1, 0, 1, 1, 14, 4'b0000, 1, "t3_next14");
      add(0, 1,  4'b0000, 1, 0, 0, 0, 0,  4'b0000, 1, "t3_done");
      // round-robin continues after last grant
      add(1, 5,  4'b0000, 0, 0, 0, 0, 0,  4'b0000, 0, "t4_idle");
      add(0, 1,  4'b0100, 0, 0, 0, 0, 0,  4'b0100, 0, "t4_cap2");
      add(0, 1,  4'b0100, 0, 0, 1, 2, 5,  4'b0000, 0, "t4_offer2");
      add(0, 1,  4'b1101, 0, 0, 1, 2, 5,  4'b1001, 0, "t4_cap03");
      add(0, 1,  4'b1101, 1, 0, 1, 3, 7,  4'b0001, 0, "t4_rr3");
      add(0, 1,  4'b0000, 1, 0, 1, 0, 7,  4'b0000, 0, "t4_rr0");
      add(0, 1,  4'b0000, 1, 0, 0, 0, 0,  4'b0000, 0, "t4_done");
      // drop counter saturation and clear
      add(1, 1,  4'b1111, 0, 0, 0, 0, 0,  4'b1111, 0, "t5_capall");
      add(0, 1,  4'b0000, 0, 0, 1, 0, 0,  4'b1110, 0, "t5_offer0");
      add(0, 1,  4'b1111, 0, 0, 1, 0, 0,  4'b1111, 3, "t5_drop3");
      add(0, 1,  4'b0000, 0, 0, 1, 0, 0,  4'b1111, 3, "t5_hold");
      add(0, 1,  4'b0011, 0, 0, 1, 0, 0,  4'b1111, 3, "t5_sat");
      add(0, 1,  4'b0000, 0, 1, 1, 0, 0,  4'b1111, 0, "t5_clr");
      add(0, 1,  4'b0001, 0, 1, 1, 0, 0,  4'b1111, 1, "t5_clr_drop");
      // setup for async reset mid-offer
      add(1, 1,  4'b0001, 0, 0, 0, 0, 0,  4'b0001, 0, "t6_cap0");
      add(0, 1,  4'b1011, 0, 0, 1, 0, 0,  4'b1010, 0, "t6_offer");

      do_reset();
      foreach (vecs[n]) begin
         apply_stimulus(vecs[n]);
         check_output(vecs[n].name, vecs[n].exp_valid, vecs[n].exp_ch, vecs[n].exp_ts,
                      vecs[n].exp_pend, vecs[n].exp_drop);
      end

      // async reset takes effect without a clock, then input held high yields a fresh edge
      rst    = 1'b1;
      sig_in = 4'b0001;
      #1;
      check_output("t6_async_rst", 0, 0, 0, 4'b0000, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_output("t6_rel_cap", 0, 0, 0, 4'b0001, 0);
      @(posedge clk);
      @(negedge clk);
      check_output("t6_rel_offer", 1, 0, 0, 4'b0000, 0);

      // randomized run against the reference model
      sig_in = '0; evt_ready = 0; clr_drop = 0;
      do_reset();
      model_reset();
      for (int n = 0; n < 3000; n++) begin
         sig_in    = sig_in ^ 4'($urandom & $urandom);
         evt_ready = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         clr_drop  = ($urandom_range(0, 15) == 0);
         @(posedge clk);
         model_step(sig_in, evt_ready, clr_drop);
         @(negedge clk);
         check_output("rand", m_valid, 2'(m_ch), 16'(m_ts), m_pend, 2'(m_drop));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
